// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - pipelined IEEE-754 adder/subtractor with RNE rounding and valid/ready flow control
//
// Purpose: three register stages (unpack/swap, align/add, normalise/round) computing a+b or a-b
// for any binary format of EXP_W exponent bits and MAN_W fraction bits. Subnormal inputs and
// results are flushed to zero. Each stage holds its data while stalled, so no op is dropped.
//
// Ports:
//   i_clk, i_reset          rising-edge clock, synchronous active-high reset
//   i_in_valid, o_in_ready  input handshake; transfer when both high at a rising edge
//   i_a, i_b, i_op          operands and select (0 = a+b, 1 = a-b)
//   i_in_tag                opaque sideband returned unchanged with the result
//   o_out_valid, i_out_ready output handshake
//   o_result, o_out_tag     rounded result and its tag
//   o_flags                 {invalid, overflow, underflow, inexact}, qualified by o_out_valid
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  input  logic                   i_op,
  input  logic [TAG_W-1:0]       i_in_tag,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [EXP_W+MAN_W:0]   o_result,
  output logic [TAG_W-1:0]       o_out_tag,
  output logic [3:0]             o_flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int M     = MAN_W + 4;          // hidden + fraction + guard, round, sticky
  localparam int SHMAX = MAN_W + 3;
  localparam int SH_W  = $clog2(M);
  localparam int LZ_W  = $clog2(M + 1);

  localparam logic [EXP_W-1:0]   EXP_ONES = '1;
  localparam logic signed [15:0] EXP_MAX  = 16'(2**EXP_W - 1);

  // special-case bundle carried through stages 1 and 2
  localparam int SP_NAN  = 4;
  localparam int SP_INV  = 3;
  localparam int SP_INF  = 2;
  localparam int SP_INFS = 1;
  localparam int SP_NZ   = 0;

  // ---------------------------------------------------------------- flow control
  logic r_s1_valid, r_s2_valid, r_s3_valid;
  logic w_s3_free, w_s2_free, w_s1_free;

  assign w_s3_free  = !r_s3_valid || i_out_ready;
  assign w_s2_free  = !r_s2_valid || w_s3_free;
  assign w_s1_free  = !r_s1_valid || w_s2_free;
  assign o_in_ready = !i_reset && w_s1_free;

  // ---------------------------------------------------------------- stage 1: unpack / swap
  logic             w_a_sign, w_b_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_swap;
  logic             w_l_sign;
  logic [EXP_W-1:0] w_l_exp, w_s_exp;
  logic [MAN_W-1:0] w_l_frac, w_s_frac;
  logic [4:0]       w_spec;

  always_comb begin
    w_a_sign = i_a[W-1];
    w_b_sign = i_b[W-1] ^ i_op;
    w_a_exp  = i_a[W-2:MAN_W];
    w_b_exp  = i_b[W-2:MAN_W];
    w_a_zero = (w_a_exp == '0);
    w_b_zero = (w_b_exp == '0);
    w_a_inf  = (w_a_exp == EXP_ONES) && (i_a[MAN_W-1:0] == '0);
    w_b_inf  = (w_b_exp == EXP_ONES) && (i_b[MAN_W-1:0] == '0);
    w_a_nan  = (w_a_exp == EXP_ONES) && (i_a[MAN_W-1:0] != '0);
    w_b_nan  = (w_b_exp == EXP_ONES) && (i_b[MAN_W-1:0] != '0);
    // subnormals become zeros of the same sign
    w_a_frac = w_a_zero ? '0 : i_a[MAN_W-1:0];
    w_b_frac = w_b_zero ? '0 : i_b[MAN_W-1:0];

    w_swap   = {w_b_exp, w_b_frac} > {w_a_exp, w_a_frac};
    w_l_sign = w_swap ? w_b_sign : w_a_sign;
    w_l_exp  = w_swap ? w_b_exp  : w_a_exp;
    w_l_frac = w_swap ? w_b_frac : w_a_frac;
    w_s_exp  = w_swap ? w_a_exp  : w_b_exp;
    w_s_frac = w_swap ? w_a_frac : w_b_frac;

    w_spec          = '0;
    // inf - inf is the only invalid case; it also yields the canonical NaN
    w_spec[SP_INV]  = w_a_inf && w_b_inf && (w_a_sign != w_b_sign);
    w_spec[SP_NAN]  = w_a_nan || w_b_nan || w_spec[SP_INV];
    w_spec[SP_INF]  = w_a_inf || w_b_inf;
    w_spec[SP_INFS] = w_a_inf ? w_a_sign : w_b_sign;
    w_spec[SP_NZ]   = w_a_zero && w_b_zero && w_a_sign && w_b_sign;
  end

  logic             r_s1_sign, r_s1_sub;
  logic [EXP_W-1:0] r_s1_exp, r_s1_d;
  logic [MAN_W:0]   r_s1_man_l, r_s1_man_s;
  logic [4:0]       r_s1_spec;
  logic [TAG_W-1:0] r_s1_tag;

  // ---------------------------------------------------------------- stage 2: align / add
  logic [SH_W-1:0] w_sh;
  logic [M-1:0]    w_s_ext, w_s_mask, w_s_shift;
  logic            w_sticky;
  logic [M:0]      w_sum;

  always_comb begin
    if (int'(r_s1_d) > SHMAX) w_sh = SH_W'(SHMAX);
    else                      w_sh = SH_W'(r_s1_d);
    w_s_ext   = {r_s1_man_s, 3'b000};
    w_s_mask  = ~({M{1'b1}} << w_sh);
    w_sticky  = |(w_s_ext & w_s_mask);
    w_s_shift = (w_s_ext >> w_sh) | {{(M-1){1'b0}}, w_sticky};
    // L >= S in magnitude, so the difference cannot go negative
    if (r_s1_sub) w_sum = {1'b0, r_s1_man_l, 3'b000} - {1'b0, w_s_shift};
    else          w_sum = {1'b0, r_s1_man_l, 3'b000} + {1'b0, w_s_shift};
  end

  logic             r_s2_sign;
  logic [EXP_W-1:0] r_s2_exp;
  logic [M:0]       r_s2_sum;
  logic [4:0]       r_s2_spec;
  logic [TAG_W-1:0] r_s2_tag;

  // ---------------------------------------------------------------- stage 3: normalise / round
  logic [LZ_W-1:0]    w_lz;
  logic               w_lz_found;
  logic [M-1:0]       w_norm;
  logic signed [15:0] w_exp_n, w_exp_r;
  logic               w_inc, w_inexact;
  logic [MAN_W+1:0]   w_rnd;
  logic [MAN_W-1:0]   w_frac;
  logic [W-1:0]       w_res;
  logic [3:0]         w_flg;

  always_comb begin
    w_lz       = '0;
    w_lz_found = 1'b0;
    for (int i = M - 1; i >= 0; i--) begin
      if (!w_lz_found) begin
        if (r_s2_sum[i]) w_lz_found = 1'b1;
        else             w_lz = w_lz + LZ_W'(1);
      end
    end

    if (r_s2_sum[M]) begin
      // carry-out: shift right one, folding the dropped bit into sticky
      w_norm  = {r_s2_sum[M:2], r_s2_sum[1] | r_s2_sum[0]};
      w_exp_n = $signed({{(16-EXP_W){1'b0}}, r_s2_exp}) + 16'sd1;
    end else begin
      w_norm  = r_s2_sum[M-1:0] << w_lz;
      w_exp_n = $signed({{(16-EXP_W){1'b0}}, r_s2_exp}) - $signed({{(16-LZ_W){1'b0}}, w_lz});
    end

    w_inexact = |w_norm[2:0];
    w_inc     = w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
    w_rnd     = {1'b0, w_norm[M-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
    w_exp_r   = w_exp_n;
    w_frac    = w_rnd[MAN_W-1:0];
    if (w_rnd[MAN_W+1]) begin
      w_exp_r = w_exp_n + 16'sd1;
      w_frac  = w_rnd[MAN_W:1];
    end

    w_flg = '0;
    if (r_s2_spec[SP_NAN]) begin
      w_res    = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      w_flg[3] = r_s2_spec[SP_INV];
    end else if (r_s2_spec[SP_INF]) begin
      w_res = {r_s2_spec[SP_INFS], EXP_ONES, {MAN_W{1'b0}}};
    end else if (r_s2_sum == '0) begin
      // exact zero is +0 unless both operands were -0
      w_res = {r_s2_spec[SP_NZ], {(W-1){1'b0}}};
    end else if (w_exp_r >= EXP_MAX) begin
      w_res = {r_s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_flg = 4'b0101;
    end else if (w_exp_r < 16'sd1) begin
      w_res = {r_s2_sign, {(W-1){1'b0}}};
      w_flg = 4'b0011;
    end else begin
      w_res    = {r_s2_sign, w_exp_r[EXP_W-1:0], w_frac};
      w_flg[0] = w_inexact;
    end
  end

  logic [W-1:0]     r_s3_result;
  logic [3:0]       r_s3_flags;
  logic [TAG_W-1:0] r_s3_tag;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_s3_result <= '0;
      r_s3_flags  <= '0;
      r_s3_tag    <= '0;
    end else begin
      if (w_s3_free) begin
        r_s3_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_s3_result <= w_res;
          r_s3_flags  <= w_flg;
          r_s3_tag    <= r_s2_tag;
        end
      end
      if (w_s2_free) r_s2_valid <= r_s1_valid;
      if (w_s1_free) r_s1_valid <= i_in_valid;
    end
  end

  // datapath registers only need their stage's valid to be cleared on reset
  always_ff @(posedge i_clk) begin
    if (w_s2_free && r_s1_valid) begin
      r_s2_sign <= r_s1_sign;
      r_s2_exp  <= r_s1_exp;
      r_s2_sum  <= w_sum;
      r_s2_spec <= r_s1_spec;
      r_s2_tag  <= r_s1_tag;
    end
    if (w_s1_free && i_in_valid) begin
      r_s1_sign  <= w_l_sign;
      r_s1_sub   <= w_a_sign ^ w_b_sign;
      r_s1_exp   <= w_l_exp;
      r_s1_d     <= w_l_exp - w_s_exp;
      r_s1_man_l <= {w_l_exp != '0, w_l_frac};
      r_s1_man_s <= {w_s_exp != '0, w_s_frac};
      r_s1_spec  <= w_spec;
      r_s1_tag   <= i_in_tag;
    end
  end

  assign o_out_valid = r_s3_valid;
  assign o_result    = r_s3_result;
  assign o_flags     = r_s3_flags;
  assign o_out_tag   = r_s3_tag;

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754 adder/subtractor with per-operation add/sub select, round-to-nearest-even, special-value handling, exception flags and valid/ready backpressure. It generalises the team's fixed 3-stage single-precision subtractor to any binary format and can stall without losing data. It sits between the RISC-V FPU issue logic and the FP writeback arbiter, and serves FADD/FSUB in both S and H formats.

## Interface
- EXP_W, 8: exponent width; legal range 4..11.
- MAN_W, 23: stored fraction width; legal range 3..52. Format width W = 1+EXP_W+MAN_W.
- TAG_W, 4: width of the opaque sideband tag carried alongside each operation.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- a, b  in  W  operands.
- op  in  1  0 = a+b, 1 = a−b.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- result  out  W  rounded result.
- out_tag  out  TAG_W  tag of the operation in result.
- flags  out  4  {invalid, overflow, underflow, inexact}; qualified by out_valid.

## Operation
- Stage 1 (capture/unpack): flip sign of b when op=1. Classify both operands as zero/normal/inf/NaN. Subnormal inputs are flushed to a zero of the same sign. Swap so that operand L has the larger magnitude, comparing {exp, frac}. Compute d = expL − expS and detect special cases.
- Stage 2 (align/add): mantissas carry the hidden 1 plus guard, round and sticky bits, so the datapath is MAN_W+4 bits with 1 bit of headroom. S is shifted right by min(d, MAN_W+3) and all shifted-out bits are ORed into sticky. Add when the signs match, subtract otherwise; L≥S, so the difference is never negative.
- Stage 3 (normalise/round): on carry-out, shift right 1 and increment the exponent. Otherwise count leading zeros and shift left; the shift is limited only by the result exponent. Apply RNE: increment if G && (R||S||lsb). Renormalise on rounding carry.
- Results and flags:
  - Any NaN input → canonical qNaN {0, all-ones, 1, 0…}. invalid=0, except inf − inf (effective subtraction of infinities), which gives qNaN with invalid=1.
  - inf combined with a finite value → that inf.
  - Exact zero sum → +0. The exception is when both operands are −0 after the op flip, which gives −0. x − x gives +0.
  - Rounded exponent ≥ all-ones → ±inf, with overflow=1 and inexact=1.
  - Exponent below 1 → ±0 (flush), with underflow=1 and inexact=1.
  - inexact=1 whenever any of G/R/S is nonzero.
- Pipeline control:
  - Each stage holds a valid bit. Stage k advances when its successor is empty or advancing.
  - The output stage advances when !out_valid || out_ready.
  - in_ready = !s1_valid || s1_advance. This is combinational from out_ready and is permitted.
  - No bubbles are inserted. Order is preserved. A stalled stage holds its data and tag unchanged.

## Timing
- Throughput: 1 op/clk when out_ready is held high.
- Latency: an op accepted at edge N has out_valid=1 with its result/tag/flags registered on edge N+2, the third register stage. This is 2 cycles after acceptance, with no stall.
- Reset (sampled at edge) clears all valid bits, result=0, flags=0, out_tag=0. While reset=1, in_ready=0 and out_valid=0.
- Reset mid-operation discards all in-flight ops. No output is produced for them.
- While out_valid && !out_ready: result, flags and out_tag are stable. After 3 stalled cycles with a full pipe, in_ready=0.
- Simultaneous output pop and input push on a full pipe: both transfer in the same cycle and occupancy is unchanged.

## Test plan
- Default params, op=1, a=0x41200000 (10.0), b=0x40400000 (3.0) → result 0x40E00000, flags 0, 2 cycles after accept.
- a=0x3F800000, b=0x33800000 (2^-24), op=0 → tie rounds to even: 0x3F800000, inexact=1. Same with b=0x33C00000 → 0x3F800001, inexact=1.
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x40A00000 − 0x40A00000 → 0x00000000.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Backpressure: 8 back-to-back ops with tags 0..7. Hold out_ready=0 for cycles 3–9, then 1. in_ready drops once 3 ops are queued, all 8 results emerge in tag order, and no result is lost or duplicated.
- Reset mid-stream: inject 3 ops, assert reset 1 cycle after the 2nd accept → out_valid stays 0 after reset. A following op 0x3F800000 + 0x3F800000 → 0x40000000.
- EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000. 0x7BFF+0x7BFF → 0x7C00 with overflow=1.
